// File: rtl/phy_tx_pkg.sv
// Shared PHY TX definitions: frame serializer state encoding, default framing
// constants and the preamble pattern helper.
package phy_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_LOAD     = 3'd3,
    ST_PAYLOAD  = 3'd4,
    ST_DONE     = 3'd5
  } tx_state_e;

  localparam int         DEFAULT_PREAMBLE_LEN = 16;
  localparam logic [7:0] DEFAULT_SFD_BYTE     = 8'hD5;

  // Preamble alternates 1,0,1,0,... starting with 1 at bit index 0.
  function automatic logic preamble_bit(input logic [5:0] bit_idx);
    return ~bit_idx[0];
  endfunction

endpackage

// File: rtl/tx_shift8.sv
// 8-bit LSB-first load/shift register with a 3-bit bit counter; reports the
// last bit of a byte and the LSB it will present after the coming edge.
module tx_shift8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] load_data,
  output logic       last,
  output logic       next_lsb
);

  logic [7:0] sreg_r;
  logic [2:0] cnt_r;

  // Shift register and bit counter: load restarts the byte, shift advances it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_r <= 8'h00;
      cnt_r  <= 3'd0;
    end else if (load) begin
      sreg_r <= load_data;
      cnt_r  <= 3'd0;
    end else if (shift) begin
      sreg_r <= {1'b0, sreg_r[7:1]};
      cnt_r  <= cnt_r + 3'd1;
    end else begin
      sreg_r <= sreg_r;
      cnt_r  <= cnt_r;
    end
  end

  assign last = (cnt_r == 3'd7);

  // Look-ahead of the bit that will sit in sreg_r[0] after this edge.
  always_comb begin
    next_lsb = sreg_r[0];
    if (load) begin
      next_lsb = load_data[0];
    end else if (shift) begin
      next_lsb = sreg_r[1];
    end else begin
      next_lsb = sreg_r[0];
    end
  end

endmodule

// File: rtl/tx_frame_serializer.sv
// Frame serializer: preamble, SFD and length-counted payload bytes sent
// LSB-first, one bit per cycle. All outputs come straight from registers.
module tx_frame_serializer
  import phy_tx_pkg::*;
#(
  parameter int         PREAMBLE_LEN = DEFAULT_PREAMBLE_LEN,
  parameter logic [7:0] SFD_BYTE     = DEFAULT_SFD_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_data_reg,
  input  logic [7:0] frame_len,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

  tx_state_e  state_r, state_next_s;
  logic       prev_start_r;
  logic       armed_r;
  logic [7:0] len_r, len_next_s;
  logic [5:0] pre_cnt_r, pre_cnt_next_s;
  logic       load_s, shift_s;
  logic [7:0] load_data_s;
  logic       last_s, next_lsb_s;
  logic       start_s;
  logic       bit_out_next_s;
  logic       byte_ready_r, bit_out_r, bit_valid_r, busy_r, done_r;

  tx_shift8 u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .shift    (shift_s),
    .load_data(load_data_s),
    .last     (last_s),
    .next_lsb (next_lsb_s)
  );

  // armed_r blocks a start level already high when reset releases.
  assign start_s = start_data_reg && !prev_start_r && armed_r && (state_r == ST_IDLE);

  // Next-state, counter and shift-register control decode.
  always_comb begin
    state_next_s   = state_r;
    len_next_s     = len_r;
    pre_cnt_next_s = pre_cnt_r;
    load_s         = 1'b0;
    shift_s        = 1'b0;
    load_data_s    = SFD_BYTE;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next_s   = ST_PREAMBLE;
          len_next_s     = frame_len;
          pre_cnt_next_s = 6'd0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (pre_cnt_r == PRE_LAST) begin
          state_next_s   = ST_SFD;
          pre_cnt_next_s = 6'd0;
          load_s         = 1'b1;
          load_data_s    = SFD_BYTE;
        end else begin
          pre_cnt_next_s = pre_cnt_r + 6'd1;
        end
      end
      ST_SFD: begin
        shift_s = 1'b1;
        if (last_s) begin
          state_next_s = (len_r != 8'd0) ? ST_LOAD : ST_DONE;
        end else begin
          state_next_s = ST_SFD;
        end
      end
      ST_LOAD: begin
        if (byte_valid) begin
          load_s       = 1'b1;
          load_data_s  = byte_in;
          state_next_s = ST_PAYLOAD;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_PAYLOAD: begin
        shift_s = 1'b1;
        if (last_s) begin
          len_next_s   = len_r - 8'd1;
          state_next_s = (len_r != 8'd1) ? ST_LOAD : ST_DONE;
        end else begin
          state_next_s = ST_PAYLOAD;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output bit for the coming cycle, so bit_out can be registered.
  always_comb begin
    bit_out_next_s = 1'b0;
    case (state_next_s)
      ST_PREAMBLE: bit_out_next_s = preamble_bit(pre_cnt_next_s);
      ST_SFD:      bit_out_next_s = next_lsb_s;
      ST_PAYLOAD:  bit_out_next_s = next_lsb_s;
      default:     bit_out_next_s = 1'b0;
    endcase
  end

  // State, counters and start-edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      len_r        <= 8'd0;
      pre_cnt_r    <= 6'd0;
      prev_start_r <= 1'b0;
      armed_r      <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      len_r        <= len_next_s;
      pre_cnt_r    <= pre_cnt_next_s;
      prev_start_r <= start_data_reg;
      armed_r      <= armed_r | ~start_data_reg;
    end
  end

  // Output registers, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready_r <= 1'b0;
      bit_out_r    <= 1'b0;
      bit_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      byte_ready_r <= (state_next_s == ST_LOAD);
      bit_out_r    <= bit_out_next_s;
      bit_valid_r  <= (state_next_s == ST_PREAMBLE) || (state_next_s == ST_SFD) ||
                      (state_next_s == ST_PAYLOAD);
      busy_r       <= (state_next_s != ST_IDLE);
      done_r       <= (state_next_s == ST_DONE);
    end
  end

  assign byte_ready = byte_ready_r;
  assign bit_out    = bit_out_r;
  assign bit_valid  = bit_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: doc/tx_frame_serializer.md
TX_FRAME_SERIALIZER -- requirements
Module: tx_frame_serializer

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 16, meaning preamble length in bits (even, 2..64).
REQ-002 SHALL have parameter SFD_BYTE, default 8'hD5, meaning start-of-frame delimiter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start_data_reg, input, 1, stretched start level from the upstream start extender.
REQ-006 SHALL have port frame_len, input, 8, payload byte count, sampled on the start edge.
REQ-007 SHALL have port byte_in, input, 8, payload byte.
REQ-008 SHALL have port byte_valid, input, 1, byte_in valid.
REQ-009 SHALL have port byte_ready, output, 1, serializer accepts byte_in this cycle.
REQ-010 SHALL have port bit_out, output, 1, serial TX bit.
REQ-011 SHALL have port bit_valid, output, 1, bit_out meaningful this cycle.
REQ-012 SHALL have port busy, output, 1, frame in progress (state != IDLE).
REQ-013 SHALL have port done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-014 SHALL detect start as start_data_reg==1 while its registered previous value==0 and state==IDLE; a start edge in any other state SHALL be ignored.
REQ-015 SHALL use states IDLE, PREAMBLE, SFD, LOAD, PAYLOAD, DONE.
REQ-016 On start, SHALL latch frame_len and enter PREAMBLE the next cycle.
REQ-017 PREAMBLE SHALL emit PREAMBLE_LEN bits, one per cycle with bit_valid=1: 1,0,1,0,... (first bit 1), then enter SFD.
REQ-018 SFD SHALL emit SFD_BYTE LSB-first over 8 cycles (D5 -> 1,0,1,0,1,0,1,1), then enter LOAD if latched length>0, else DONE.
REQ-019 LOAD SHALL drive byte_ready=1 and bit_valid=0; on byte_valid&&byte_ready, SHALL capture byte_in into the shift register and enter PAYLOAD; without byte_valid, SHALL remain in LOAD indefinitely.
REQ-020 PAYLOAD SHALL emit the captured byte LSB-first over 8 cycles with bit_valid=1; after bit 7, SHALL decrement remaining count and enter LOAD if count>0, else DONE.
REQ-021 byte_ready SHALL be 1 only in LOAD.
REQ-022 DONE SHALL last exactly one cycle with done=1, bit_valid=0, then return to IDLE.
REQ-023 In IDLE, LOAD and DONE, bit_out SHALL be 0 and bit_valid SHALL be 0.
REQ-024 Bit counter SHALL be 6 bits wide; byte counter 8 bits; frame_len=255 SHALL yield 255 payload bytes without wrap.
REQ-025 A new start edge coinciding with the DONE cycle SHALL be ignored; one arriving in IDLE the cycle after DONE SHALL be accepted.
REQ-026 Total bit_valid cycles per frame SHALL equal PREAMBLE_LEN + 8 + 8*frame_len.

Reset
REQ-027 rst SHALL force state IDLE, all counters 0, shift register 0, previous-start register 0 and all outputs 0 on the next clock edge, including mid-frame.
REQ-028 After rst deasserts while start_data_reg is already 1, no frame SHALL start until start_data_reg returns to 0 and rises again.

Structure
REQ-029 State encoding and the default SFD/preamble constants SHALL reside in shared package phy_tx_pkg.
REQ-030 A sub-module tx_shift8 (8-bit LSB-first load/shift register with bit counter) SHALL be used for SFD and PAYLOAD serialization.

Verification
REQ-031 rst then start edge with frame_len=0 -> 16 preamble bits 1010..., then 1,0,1,0,1,0,1,1, then done pulse; 24 bit_valid cycles.
REQ-032 frame_len=2, bytes 8'h01,8'h80 always valid -> payload bits 10000000 then 00000001, one gap cycle before each byte, done after.
REQ-033 frame_len=1, byte_valid held low 5 cycles in LOAD -> byte_ready high 5+1 cycles, bit_valid 0, then byte serialized.
REQ-034 Second start edge during PAYLOAD -> ignored; single frame, one done pulse.
REQ-035 rst asserted at preamble bit 5 -> next cycle busy=0, bit_valid=0; re-start produces full 16-bit preamble.
REQ-036 frame_len=255 -> 24+2040 bit_valid cycles, 255 byte handshakes, exactly one done.
